// File: rtl/pc_stack_unit.sv
// Program counter with increment, absolute load, PC-relative branch and a
// hardware return-address stack for call/return nesting.
module pc_stack_unit #(
  parameter int unsigned       WIDTH     = 4,
  parameter int unsigned       DEPTH     = 4,
  parameter int unsigned       OFF_W     = 4,
  parameter logic [WIDTH-1:0]  RESET_VEC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             set_pc,
  input  logic [WIDTH-1:0] pc_init,
  input  logic             branch,
  input  logic [OFF_W-1:0] branch_off,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] pc_curr,
  output logic             stack_empty,
  output logic             stack_full,
  output logic             stack_err
);

  localparam int unsigned SP_W  = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [SP_W-1:0]  sp_q, sp_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] stack_q [DEPTH];

  logic             push;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] off_ext;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  assign pc_inc  = pc_q + WIDTH'(1);
  assign off_ext = WIDTH'($signed(branch_off));
  assign wr_idx  = IDX_W'(sp_q);
  assign rd_idx  = IDX_W'(sp_q - SP_W'(1));

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    pc_d  = pc_q;
    sp_d  = sp_q;
    err_d = err_q;
    push  = 1'b0;
    if (set_pc) begin
      pc_d = pc_init;
    end else if (en) begin
      if (ret) begin
        if (sp_q != '0) begin
          pc_d = stack_q[rd_idx];
          sp_d = sp_q - SP_W'(1);
        end else begin
          pc_d  = pc_inc;
          err_d = 1'b1;
        end
      end else if (call) begin
        // The jump happens even when the push is refused on overflow.
        pc_d = pc_init;
        if (sp_q != SP_FULL) begin
          push = 1'b1;
          sp_d = sp_q + SP_W'(1);
        end else begin
          err_d = 1'b1;
        end
      end else if (branch) begin
        pc_d = pc_q + off_ext;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_VEC;
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  // NOTE: the stack storage is deliberately not reset; entries above sp are
  // never read, so resetting them would only cost area and routing.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      stack_q[wr_idx] <= pc_inc;
    end
  end

  assign pc_curr     = pc_q;
  assign stack_empty = (sp_q == '0);
  assign stack_full  = (sp_q == SP_FULL);
  assign stack_err   = err_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Scoreboard bench for pc_stack_unit: the driver queues hand-computed
// expectations per edge, and a monitor pops and compares them on the falling edge.
module tb_pc_stack_unit;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, en, set_pc, branch, call, ret;
  logic [W-1:0] pc_init, branch_off;
  logic [W-1:0] pc_curr;
  logic         stack_empty, stack_full, stack_err;

  typedef struct {
    string        name;
    logic [W-1:0] pc;
    logic         emp;
    logic         full;
    logic         err;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  pc_stack_unit #(.WIDTH(4), .DEPTH(2), .OFF_W(4), .RESET_VEC(4'h0)) dut (
    .clk(clk), .rst(rst), .en(en), .set_pc(set_pc), .pc_init(pc_init),
    .branch(branch), .branch_off(branch_off), .call(call), .ret(ret),
    .pc_curr(pc_curr), .stack_empty(stack_empty), .stack_full(stack_full),
    .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act_pc, input logic act_e,
                       input logic act_f, input logic act_r, input exp_t e);
    tests_run++;
    if (act_pc !== e.pc || act_e !== e.emp || act_f !== e.full || act_r !== e.err) begin
      tests_failed++;
      $display("FAIL %s: got pc=%h emp=%b full=%b err=%b, expected pc=%h emp=%b full=%b err=%b",
               name, act_pc, act_e, act_f, act_r, e.pc, e.emp, e.full, e.err);
    end
  endtask

  // Monitor: one registered response per edge, sampled away from the rising edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check(e.name, pc_curr, stack_empty, stack_full, stack_err, e);
    end
  end

  // Control field order: {rst, set_pc, en, branch, call, ret}
  task automatic step(input string nm, input logic [5:0] ctl, input logic [W-1:0] init,
                      input logic [W-1:0] off, input logic [W-1:0] epc,
                      input logic eemp, input logic efull, input logic eerr);
    exp_t e;
    @(negedge clk);
    {rst, set_pc, en, branch, call, ret} = ctl;
    pc_init    = init;
    branch_off = off;
    @(posedge clk);
    #1;
    e.name = nm; e.pc = epc; e.emp = eemp; e.full = efull; e.err = eerr;
    exp_q.push_back(e);
  endtask

  initial begin
    {rst, set_pc, en, branch, call, ret} = 6'b0;
    pc_init = '0; branch_off = '0;

    // rst  set  en  br  call ret
    step("reset",        6'b100000, 4'h0, 4'h0, 4'h0, 1, 0, 0);
    step("inc1",         6'b001000, 4'h0, 4'h0, 4'h1, 1, 0, 0);
    step("inc2",         6'b001000, 4'h0, 4'h0, 4'h2, 1, 0, 0);
    step("inc3",         6'b001000, 4'h0, 4'h0, 4'h3, 1, 0, 0);
    step("load_f",       6'b010000, 4'hF, 4'h0, 4'hF, 1, 0, 0);
    step("inc_wrap",     6'b001000, 4'h0, 4'h0, 4'h0, 1, 0, 0);

    step("load9_stall",  6'b010000, 4'h9, 4'h0, 4'h9, 1, 0, 0);
    step("stall1",       6'b000000, 4'h0, 4'h0, 4'h9, 1, 0, 0);
    step("stall2",       6'b000000, 4'h0, 4'h0, 4'h9, 1, 0, 0);
    step("stall3",       6'b000000, 4'h0, 4'h0, 4'h9, 1, 0, 0);
    step("inc_after",    6'b001000, 4'h0, 4'h0, 4'hA, 1, 0, 0);

    step("load3",        6'b011000, 4'h3, 4'h0, 4'h3, 1, 0, 0);
    step("branch_neg",   6'b001100, 4'h0, 4'hE, 4'h1, 1, 0, 0);
    step("load14",       6'b011000, 4'hE, 4'h0, 4'hE, 1, 0, 0);
    step("branch_wrap",  6'b001100, 4'h0, 4'h3, 4'h1, 1, 0, 0);
    step("branch_stall", 6'b000100, 4'h0, 4'h3, 4'h1, 1, 0, 0);

    step("load2",        6'b011000, 4'h2, 4'h0, 4'h2, 1, 0, 0);
    step("call8",        6'b001010, 4'h8, 4'h0, 4'h8, 0, 0, 0);
    step("call12",       6'b001010, 4'hC, 4'h0, 4'hC, 0, 1, 0);
    step("ret_9",        6'b001001, 4'h0, 4'h0, 4'h9, 0, 0, 0);
    step("ret_3",        6'b001001, 4'h0, 4'h0, 4'h3, 1, 0, 0);

    step("call8_b",      6'b001010, 4'h8, 4'h0, 4'h8, 0, 0, 0);
    step("call12_b",     6'b001010, 4'hC, 4'h0, 4'hC, 0, 1, 0);
    step("call_ovf",     6'b001010, 4'h5, 4'h0, 4'h5, 0, 1, 1);
    step("load_keeps",   6'b011000, 4'h6, 4'h0, 4'h6, 0, 1, 1);
    step("ret_after_ovf",6'b001001, 4'h0, 4'h0, 4'h9, 0, 0, 1);
    step("reset2",       6'b100000, 4'h0, 4'h0, 4'h0, 1, 0, 0);
    step("load6",        6'b011000, 4'h6, 4'h0, 4'h6, 1, 0, 0);
    step("ret_udf",      6'b001001, 4'h0, 4'h0, 4'h7, 1, 0, 1);
    step("err_sticky",   6'b001000, 4'h0, 4'h0, 4'h8, 1, 0, 1);
    step("loadF",        6'b011000, 4'hF, 4'h0, 4'hF, 1, 0, 1);
    step("call_from_top",6'b001010, 4'h2, 4'h0, 4'h2, 0, 0, 1);
    step("ret_wrap0",    6'b001001, 4'h0, 4'h0, 4'h0, 1, 0, 1);

    step("reset3",       6'b100000, 4'h0, 4'h0, 4'h0, 1, 0, 0);
    step("load3_c",      6'b011000, 4'h3, 4'h0, 4'h3, 1, 0, 0);
    step("call7",        6'b001010, 4'h7, 4'h0, 4'h7, 0, 0, 0);
    step("call_and_ret", 6'b001011, 4'hB, 4'h0, 4'h4, 1, 0, 0);
    step("call9",        6'b001010, 4'h9, 4'h0, 4'h9, 0, 0, 0);
    step("rst_with_call",6'b101010, 4'h5, 4'h0, 4'h0, 1, 0, 0);
    step("stall_call",   6'b000010, 4'h5, 4'h0, 4'h0, 1, 0, 0);
    step("load1",        6'b011000, 4'h1, 4'h0, 4'h1, 1, 0, 0);
    step("branch_call",  6'b001110, 4'h6, 4'h3, 4'h6, 0, 0, 0);
    step("branch_ret",   6'b001101, 4'h0, 4'h3, 4'h2, 1, 0, 0);

    {rst, set_pc, en, branch, call, ret} = 6'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not finish, expected finish before 20000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
Parametrised program counter, the successor to the 4-bit pc. It holds the current instruction address and advances it by increment, absolute load, PC-relative branch, call or return. A hardware return-address stack supports one-level-per-entry subroutine nesting. It sits at the front of the fetch path and drives the instruction memory address.

Parameters:
WIDTH, 4, PC / address width in bits.
DEPTH, 4, return-address stack entries (>=1).
OFF_W, 4, signed branch offset width (<=WIDTH).
RESET_VEC, 0, PC value after reset.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
en  input  1  advance enable; 0 = stall (hold everything except load).
set_pc  input  1  absolute load of pc_init (works even when en=0).
pc_init  input  WIDTH  absolute load / call target.
branch  input  1  PC-relative branch.
branch_off  input  OFF_W  signed two's-complement offset.
call  input  1  push return address, jump to pc_init.
ret  input  1  pop return address into PC.
pc_curr  output  WIDTH  current PC (registered).
stack_empty  output  1  stack holds 0 entries.
stack_full  output  1  stack holds DEPTH entries.
stack_err  output  1  sticky overflow/underflow flag.

Behaviour:
- Only one clock and one reset: synchronous, active-high rst sampled on the rising edge of clk.
- Reset: pc_curr=RESET_VEC, stack pointer=0, stack_empty=1, stack_full=0, stack_err=0. Stack contents don't-care. Reset overrides all other inputs in the same cycle, including mid-nesting.
- All updates occur on the rising edge of clk. pc_curr reflects the new value one cycle after the request (1-cycle latency). There is no combinational path from inputs to outputs.
- Priority per edge: rst > set_pc > (en=0: hold) > ret > call > branch > increment.
  - set_pc: pc <= pc_init. Stack is untouched.
  - en=0 without set_pc: pc, stack and flags all hold.
  - ret:
    - Non-empty stack: pc <= top entry; pointer decrements.
    - Empty stack: pc <= pc_curr+1 and stack_err <= 1.
  - call:
    - Not full: push (pc_curr+1) mod 2^WIDTH, then pc <= pc_init.
    - Full: no push, pointer unchanged, stack_err <= 1, but the jump to pc_init still happens.
  - branch: pc <= (pc_curr + sign_extend(branch_off)) mod 2^WIDTH.
  - Default: pc <= (pc_curr + 1) mod 2^WIDTH.
- Simultaneous requests:
  - call+ret in one cycle: only ret executes; call is ignored (no push).
  - branch with call or ret: branch is ignored.
- Arithmetic wraps modulo 2^WIDTH with no carry out. A return address of the top address wraps to 0.
- Stack is LIFO, organised as a register array plus pointer sp (0..DEPTH).
  - stack_empty = (sp==0).
  - stack_full = (sp==DEPTH).
  - Both are derived from the registered sp.
- stack_err: sticky; cleared only by rst.
- X-free: all outputs are defined from the first edge after rst.

Test Plan:
(All with WIDTH=4, DEPTH=2, OFF_W=4, RESET_VEC=0 unless noted.)
1. Reset then increment: rst=1 for 1 edge, then en=1 for 3 edges -> pc_curr 0,1,2,3; stack_empty=1, stack_err=0. From pc=4'hF, one increment -> 0.
2. Load and stall: set_pc=1, pc_init=9 with en=0 -> pc=9. Then en=0 for 3 edges -> pc stays 9. Then en=1 -> pc=10.
3. Branch: at pc=3, branch_off=4'b1110 (-2) -> pc=1. At pc=14, branch_off=3 -> pc=1 (wrap).
4. Nested call/return: at pc=2, call to 8 -> pc=8, stack=[3], stack_empty=0. At pc=8, call to 12 -> pc=12, stack_full=1. Then ret -> pc=9; ret -> pc=3, stack_empty=1, stack_err=0.
5. Overflow/underflow:
   - Third call while full, target 5 -> pc=5, sp stays 2, stack_err=1.
   - After rst, ret at pc=6 -> pc=7, stack_err=1.
   - stack_err stays 1 until the next rst.
6. Conflicts and reset:
   - call+ret together with one entry (value 4) on the stack -> pc=4, stack_empty=1, no push.
   - rst asserted together with call -> pc=0, sp=0, stack_err=0.
